// File: rtl/data_mem_responder.sv
// Single-port data memory for a RISC-V style core: one outstanding load/store at a time,
// fixed response latency, byte/half/word access with sign-extended loads and error reporting.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic [31:0]   word_rd;
    logic [31:0]   wlane;
    logic [3:0]    be;
    logic          bad;
    logic          fire;
    logic          mem_we;

    function automatic logic is_illegal(input logic [2:0] size, input logic [31:0] addr);
        logic bad_size;
        logic misaligned;
        logic out_of_range;
        bad_size     = (size > 3'b010);
        misaligned   = ((size == 3'b001) && addr[0]) ||
                       ((size == 3'b010) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= DEPTH_U);
        return bad_size || misaligned || out_of_range;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] en;
        case (size)
            3'b000:  en = 4'b0001 << off;
            3'b001:  en = off[1] ? 4'b1100 : 4'b0011;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    function automatic logic signed [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                                       input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = b;
            3'b001:  r = h;
            default: r = word;
        endcase
        return r;
    endfunction

    assign widx    = addr_q[AW+1:2];
    assign word_rd = mem[widx];
    assign bad     = is_illegal(size_q, addr_q);
    assign be      = lane_enable(size_q, addr_q[1:0]);
    // Replicating the store data across lanes lets the byte enables pick the right copy.
    assign wlane   = (size_q == 3'b000) ? {4{wdata_q[7:0]}} :
                     (size_q == 3'b001) ? {2{wdata_q[15:0]}} : wdata_q;
    assign fire    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we  = fire && we_q && !bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = bad;
                    rdata_d = (bad || we_q) ? 32'd0 : $unsigned(load_extend(size_q, addr_q[1:0], word_rd));
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed transactions with literal expectations, then
// randomized traffic checked against a word-array model, plus a LATENCY=1 throughput run.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [2:0]  req_size = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid_1 = 1'b0, req_we_1 = 1'b0, resp_ready_1 = 1'b1;
    logic [2:0]  req_size_1 = 3'd0;
    logic [31:0] req_addr_1 = 32'd0, req_wdata_1 = 32'd0;
    logic        req_ready_1, resp_valid_1, resp_err_1;
    logic [31:0] resp_rdata_1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mmem [0:DEPTH-1];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1), .req_size(req_size_1),
        .req_addr(req_addr_1), .req_wdata(req_wdata_1),
        .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_rdata(resp_rdata_1),
        .resp_err(resp_err_1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired without the expected event", name);
    endtask

    // Memory model: word array, lane masks and plain arithmetic sign extension.
    function automatic exp_t model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t        e;
        int unsigned wi, sh;
        logic [31:0] w, mask, v;
        wi = a / 4;
        sh = 8 * (a % 4);
        e.err = (sz > 3'd2) || (sz == 3'd1 && (a % 2) != 0) || (sz == 3'd2 && (a % 4) != 0) ||
                (wi >= DEPTH);
        e.rdata = 32'd0;
        if (e.err) return e;
        w    = mmem[wi];
        mask = (sz == 3'd0) ? (32'hFF << sh) : (sz == 3'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        if (we) begin
            mmem[wi] = (w & ~mask) | ((wd << sh) & mask);
        end else begin
            v = (w & mask) >> sh;
            if (sz == 3'd0 && v >= 32'd128)   v = v - 32'd256;
            if (sz == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            e.rdata = v;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_resp");
            end else begin
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic er);
        exp_t e;
        int   n;
        bit   got;
        rd = 32'd0;
        er = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        resp_ready = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) begin
            timeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e = model(we, sz, a, wd);
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!got) begin
            timeout("resp");
            resp_ready = 1'b1;
            return;
        end
        check("latency", 32'(n), 32'(LAT));
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'($urandom_range(0, 1)); req_addr = 32'h0000_0004;
            @(negedge clk);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, rd);
            check("hold_err", 32'(resp_err), 32'(er));
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("resp_drop", 32'(resp_valid), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic set_req1(input int k, input logic [31:0] d);
        req_we_1    = (k < 3);
        req_size_1  = 3'd2;
        req_addr_1  = 32'(4 * (k % 3));
        req_wdata_1 = d;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        logic [31:0] d1 [6];
        logic [31:0] exp1 [6];
        int          cyc, last_acc, acc_n, resp_n;
        bit          accepting, got;
        logic [2:0]  sz;
        logic [31:0] a;
        int unsigned r, wi;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_addr = 32'd0; req_wdata = $urandom;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_valid_1", 32'(resp_valid_1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        e = model(1'b1, 3'd2, 32'd0, req_wdata);
        exp_q.push_back(e);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("accept_after_reset", 32'(req_ready), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) timeout("first_txn_drain");

        for (int w = 1; w < 16; w++) begin
            do_req(1'b1, 3'd2, 32'(4 * w), (w == 8) ? 32'd0 : $urandom, 0, rd, er);
        end

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_10_err", 32'(er), 32'd0);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        do_req(1'b1, 3'd0, 32'h11, 32'h55, 0, rd, er);
        check("sb_11_err", 32'(er), 32'd0);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_10_after_sb", rd, 32'hDEAD55EF);
        do_req(1'b0, 3'd0, 32'h13, 32'd0, 0, rd, er);
        check("lb_13", rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'd1, 32'h10, 32'd0, 0, rd, er);
        check("lh_10", rd, 32'h000055EF);

        do_req(1'b0, 3'd2, 32'h12, 32'd0, 0, rd, er);
        check("lw_12_err", 32'(er), 32'd1);
        check("lw_12_rdata", rd, 32'd0);
        do_req(1'b1, 3'd1, 32'h13, 32'hABCD, 0, rd, er);
        check("sh_13_err", 32'(er), 32'd1);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_10_unchanged", rd, 32'hDEAD55EF);
        do_req(1'b0, 3'd3, 32'h10, 32'd0, 0, rd, er);
        check("size3_err", 32'(er), 32'd1);
        do_req(1'b0, 3'd2, 32'h1000, 32'd0, 0, rd, er);
        check("lw_1000_err", 32'(er), 32'd1);
        check("lw_1000_rdata", rd, 32'd0);

        do_req(1'b0, 3'd2, 32'h10, 32'd0, 5, rd, er);
        check("held_lw_10", rd, 32'hDEAD55EF);

        // Store to 0x20 aborted by reset while still waiting for its write edge.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        resp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) timeout("abort_accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("abort_hold_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        do_req(1'b0, 3'd2, 32'h20, 32'd0, 0, rd, er);
        check("lw_20_after_abort", rd, 32'd0);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, rd, er);
        check("lw_10_after_reset", rd, 32'hDEAD55EF);

        for (int t = 0; t < 200; t++) begin
            r  = $urandom_range(0, 19);
            sz = (r < 17) ? 3'(r % 3) : 3'(3 + (r % 5));
            wi = ($urandom_range(0, 15) == 0) ? 32'(DEPTH) + $urandom_range(0, 100) : $urandom_range(0, 15);
            a  = 32'(wi * 4 + $urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), sz, a, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, rd, er);
        end

        // LATENCY=1 instance: requests held valid, resp_ready tied high.
        for (int i = 0; i < 3; i++) begin
            d1[i]       = $urandom;
            exp1[i]     = 32'd0;
            exp1[i + 3] = d1[i];
        end
        cyc = 0; last_acc = 0; acc_n = 0; resp_n = 0;
        @(posedge clk); #1;
        set_req1(0, d1[0]);
        req_valid_1 = 1'b1;
        resp_ready_1 = 1'b1;
        while (resp_n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (resp_valid_1) begin
                check("b2b_rdata", resp_rdata_1, exp1[resp_n]);
                check("b2b_err", 32'(resp_err_1), 32'd0);
                resp_n++;
            end
            accepting = req_valid_1 && req_ready_1;
            @(posedge clk);
            if (accepting) begin
                if (acc_n > 0) check("b2b_gap", 32'(cyc - last_acc), 32'd3);
                last_acc = cyc;
                acc_n++;
                #1;
                if (acc_n < 6) set_req1(acc_n, (acc_n < 3) ? d1[acc_n] : 32'd0);
                else req_valid_1 = 1'b0;
            end
        end
        if (resp_n < 6) timeout("b2b_responses");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
